ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_host_tx.sv | 151 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - host-side command handshake for the PS/2 transmitter
//
// Purpose: bundles the command byte, start request and transfer status
// exchanged between the host logic and ps2_host_tx.
// Signals:
//   data  [7:0] command byte, captured on an accepted start
//   start       single-cycle transmit request
//   busy        high from the cycle after an accepted start until done
//   done        single-cycle pulse at the end of every transfer
//   error       status of the last transfer, held until the next start
// Modports: master = requester, slave = ps2_host_tx.

interface ps2_host_tx_if;
  logic [7:0] data;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output data, output start, input busy, input done, input error);
  modport slave  (input data, input start, output busy, output done, output error);
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Purpose: sends one command byte to a PS/2 device: inhibits the clock,
// issues a request-to-send, shifts out data/parity/stop on device clock
// falling edges, samples the device acknowledge and reports status.
// Ports:
//   clk         system clock, sole clock domain
//   rst         asynchronous active-high reset
//   ps2clk_in   PS/2 clock pad input (asynchronous)
//   ps2data_in  PS/2 data pad input (asynchronous)
//   ps2clk_oe   1 = pull PS/2 clock low
//   ps2data_oe  1 = pull PS/2 data low
//   host        command handshake (ps2_host_tx_if.slave)

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3360,
  parameter int TIMEOUT_CYCLES = 560000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2clk_in,
  input  logic         ps2data_in,
  output logic         ps2clk_oe,
  output logic         ps2data_oe,
  ps2_host_tx_if.slave host
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE, DONE} state_t;

  state_t           state, state_next;
  logic [1:0]       clk_sync, data_sync;
  logic             clk_prev;
  logic             fall;
  logic [8:0]       shift_q;   // {parity, data}, shifted out LSB first
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       bit_cnt;
  logic             drive_q;   // data drive during SEND (1 = pull low)
  logic             error_q;
  logic             timeout;

  // Synchronizers reset to 1 (idle bus level) so reset release cannot
  // fake a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2clk_in};
      data_sync <= {data_sync[0], ps2data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[1];
  // to_cnt holds the number of cycles elapsed since clock release,
  // counting the current one.
  assign timeout = (state == SEND || state == ACK || state == WAITIDLE) &&
                   (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ps2clk_oe  = 1'b0;
    ps2data_oe = 1'b0;
    case (state)
      IDLE:     if (host.start) state_next = INHIBIT;
      INHIBIT: begin
        ps2clk_oe = 1'b1;
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) state_next = REQ;
      end
      REQ: begin
        ps2clk_oe  = 1'b1;
        ps2data_oe = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        ps2data_oe = drive_q & ~timeout;
        if (timeout)                     state_next = DONE;
        else if (fall && bit_cnt == 4'd9) state_next = ACK;
      end
      ACK: begin
        if (timeout)   state_next = DONE;
        else if (fall) state_next = WAITIDLE;
      end
      WAITIDLE: begin
        if (timeout || (clk_sync[1] && data_sync[1])) state_next = DONE;
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      inh_cnt <= '0;
      to_cnt  <= '0;
      bit_cnt <= '0;
      drive_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (host.start) begin
            shift_q <= {~^host.data, host.data};
            error_q <= 1'b0;
            inh_cnt <= '0;
          end
        end
        INHIBIT: inh_cnt <= inh_cnt + 1'b1;
        REQ: begin
          bit_cnt <= '0;
          to_cnt  <= TO_W'(1);
          drive_q <= 1'b1;      // start bit stays on the line until edge 1
        end
        SEND, ACK, WAITIDLE: begin
          if (timeout) begin
            error_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (fall && state == SEND) begin
              if (bit_cnt != 4'd10) bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt < 4'd9) begin
                drive_q <= ~shift_q[0];
                shift_q <= shift_q >> 1;
              end else begin
                drive_q <= 1'b0;  // stop bit: release data
              end
            end
            if (fall && state == ACK && data_sync[1]) error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign host.busy  = (state != IDLE);
  assign host.done  = (state == DONE);
  assign host.error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;

  localparam int INH = 16;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2clk_oe, ps2data_oe;
  wire  ps2clk_line  = dev_clk & ~ps2clk_oe;
  wire  ps2data_line = dev_data & ~ps2data_oe;

  int tests = 0;
  int fails = 0;

  logic [10:0] dev_samples;
  bit          dev_ok;

  ps2_host_tx_if hif ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2clk_in  (ps2clk_line),
    .ps2data_in (ps2data_line),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .host       (hif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as the device should see it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] expected_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // mode: 0 ack, 1 no ack, 2 never clocks, 3 stop after 4th falling edge
  task automatic device(input int mode);
    int guard;
    dev_ok = 1'b1;
    dev_samples = '0;
    if (mode == 2) return;
    guard = 0;
    while (!(ps2clk_line && !ps2data_line) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      dev_ok = 1'b0;
      return;
    end
    repeat (20) @(negedge clk);
    dev_samples[0] = ps2data_line;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      repeat (10) @(negedge clk);
      dev_samples[k] = ps2data_line;
      if (mode == 3 && k == 4) return;
      if (k == 10 && mode == 0) dev_data = 1'b0;
      repeat (10) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    dev_data = 1'b1;
  endtask

  // Samples every cycle starting with the one after the accepted start.
  task automatic monitor(output int inh_len, output int req_len, output int rel_idx,
                         output int done_idx, output bit busy_ok, output bit got_done,
                         output logic err_done, output logic err_start,
                         output logic oe_done, output logic oe_pre);
    logic oe_prev;
    inh_len = 0; req_len = 0; rel_idx = -1; done_idx = -1;
    busy_ok = 1'b1; got_done = 1'b0; err_done = 1'bx; oe_done = 1'bx;
    oe_pre = 1'bx; oe_prev = 1'bx;
    err_start = hif.error;
    for (int n = 0; n < 3000; n++) begin
      if (!hif.busy) busy_ok = 1'b0;
      if (ps2clk_oe && !ps2data_oe) inh_len++;
      if (ps2clk_oe && ps2data_oe) req_len++;
      if (!ps2clk_oe && req_len > 0 && rel_idx < 0) rel_idx = n;
      if (hif.done) begin
        got_done = 1'b1;
        done_idx = n;
        err_done = hif.error;
        oe_done  = ps2clk_oe | ps2data_oe;
        oe_pre   = oe_prev;
        break;
      end
      oe_prev = ps2clk_oe | ps2data_oe;
      @(negedge clk);
    end
  endtask

  // Called at a negedge; the start pulse is seen on the very next posedge.
  task automatic transfer(input string tag, input logic [7:0] d, input int mode,
                          input bit intrude, input logic [7:0] intrude_data);
    int inh_len, req_len, rel_idx, done_idx;
    bit busy_ok, got_done;
    logic err_done, err_start, oe_done, oe_pre, exp_err;
    exp_err = (mode != 0);
    hif.data  = d;
    hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    fork
      device(mode);
      monitor(inh_len, req_len, rel_idx, done_idx, busy_ok, got_done,
              err_done, err_start, oe_done, oe_pre);
      if (intrude) begin
        repeat (100) @(negedge clk);
        hif.data  = intrude_data;
        hif.start = 1'b1;
        @(negedge clk);
        hif.start = 1'b0;
      end
    join
    check({tag, " done_seen"}, got_done, 1'b1);
    check({tag, " err_cleared"}, err_start, 1'b0);
    check({tag, " inhibit_len"}, inh_len, INH);
    check({tag, " req_len"}, req_len, 1);
    check({tag, " busy_span"}, busy_ok, 1'b1);
    check({tag, " error"}, err_done, exp_err);
    check({tag, " oe_at_done"}, oe_done, 1'b0);
    if (mode == 2) begin
      check({tag, " timeout_cycles"}, done_idx - rel_idx, TMO);
      check({tag, " oe_before_done"}, oe_pre, 1'b0);
    end else begin
      check({tag, " device_ok"}, dev_ok, 1'b1);
      check({tag, " frame"}, dev_samples, expected_frame(d));
    end
    @(negedge clk);
    check({tag, " busy_after"}, hif.busy, 1'b0);
    check({tag, " done_pulse"}, hif.done, 1'b0);
    repeat (20) @(negedge clk);
    check({tag, " error_held"}, hif.error, exp_err);
  endtask

  initial begin
    logic [7:0] rd;
    int rm;
    hif.data  = 8'h00;
    hif.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset clk_oe", ps2clk_oe, 1'b0);
    check("reset data_oe", ps2data_oe, 1'b0);
    check("reset busy", hif.busy, 1'b0);
    check("reset done", hif.done, 1'b0);
    check("reset error", hif.error, 1'b0);
    rst = 1'b0;

    transfer("ed_ack", 8'hED, 0, 1'b0, 8'h00);
    transfer("f4_ack", 8'hF4, 0, 1'b0, 8'h00);
    transfer("01_nack", 8'h01, 1, 1'b0, 8'h00);
    transfer("timeout", 8'h3C, 2, 1'b0, 8'h00);
    transfer("a3_intrude", 8'hA3, 0, 1'b1, 8'h55);

    // Reset in the middle of SEND
    hif.data  = 8'h96;
    hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    device(3);
    check("rst_mid device_ok", dev_ok, 1'b1);
    check("rst_mid partial_frame", dev_samples[4:0], expected_frame(8'h96) & 11'h01F);
    check("rst_mid busy_before", hif.busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid clk_oe", ps2clk_oe, 1'b0);
    check("rst_mid data_oe", ps2data_oe, 1'b0);
    check("rst_mid busy", hif.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    transfer("after_rst", 8'h5A, 0, 1'b0, 8'h00);

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      rm = ($urandom_range(0, 3) == 0) ? 1 : 0;
      transfer($sformatf("rand%0d_%02h", i, rd), rd, rm, 1'b0, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
